// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Next-PC source selection driven by the FSM.
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP  = 4;
  // Signed so that a size cast to a wider PC sign-extends the upper ones.
  localparam logic signed [31:0] ALIGN_MASK = -32'sd4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/acknowledge bus.
interface fetch_if #(
  parameter int N = 32
);
  logic         req;
  logic [N-1:0] addr;
  logic         ack;
  logic [N-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC source selection.
module fetch_pc_reg #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC),
  parameter int unsigned PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  fetch_pkg::pc_sel_e sel,
  input  logic [N-1:0]       redirect_tgt,
  input  logic [N-1:0]       pending_tgt,
  output logic [N-1:0]       pc
);
  import fetch_pkg::*;

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;

  // Choose the next PC; sequential increment wraps naturally modulo 2^N.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_INC:   pc_d = pc_q + N'(PC_STEP);
      PC_REDIR: pc_d = redirect_tgt;
      PC_PEND:  pc_d = pending_tgt;
      default:  pc_d = pc_q;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs one imem transaction at a
// time, holds the fetched word for decode, and handles stalls/redirects.
module fetch_ctrl #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC),
  parameter int unsigned  PC_STEP  = fetch_pkg::PC_STEP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  fetch_if.master      imem,
  output logic         if_valid,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_instr,
  output logic         busy
);
  import fetch_pkg::*;

  state_e       state_q, state_d;
  logic         kill_q, kill_d;
  logic [N-1:0] pend_q, pend_d;
  logic         if_valid_q, if_valid_d;
  logic [N-1:0] if_pc_q, if_pc_d;
  logic [N-1:0] if_instr_q, if_instr_d;
  pc_sel_e      pc_sel;
  logic [N-1:0] pc;
  logic [N-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & N'(ALIGN_MASK);

  fetch_pc_reg #(
    .N        (N),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk          (clk),
    .reset        (reset),
    .sel          (pc_sel),
    .redirect_tgt (redirect_aligned),
    .pending_tgt  (pend_q),
    .pc           (pc)
  );

  // Next-state, kill/pending target, IF output capture and PC source select.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    pc_sel     = PC_HOLD;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_sel = PC_REDIR;
        if (start)          state_d = S_REQ;
      end
      S_REQ: begin
        if (imem.ack) begin
          if (redirect_valid) begin
            // Newest target wins over any latched one; data is stale.
            pc_sel = PC_REDIR;
            kill_d = 1'b0;
          end else if (kill_q) begin
            pc_sel = PC_PEND;
            kill_d = 1'b0;
          end else begin
            if_instr_d = imem.rdata;
            if_pc_d    = pc;
            if_valid_d = 1'b1;
            pc_sel     = PC_INC;
            state_d    = S_OUT;
          end
        end else if (redirect_valid) begin
          // Address must stay stable until ack; remember the target instead.
          pend_d = redirect_aligned;
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_sel     = PC_REDIR;
          state_d    = start ? S_REQ : S_IDLE;
        end else if (!stall) begin
          if_valid_d = 1'b0;
          state_d    = start ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      pend_q     <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem.req  = (state_q == S_REQ);
  assign imem.addr = pc;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  fetch_if #(.N(32)) imem_bus ();

  fetch_ctrl #(.N(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; observe 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_bus.ack = 1'b0; imem_bus.rdata = '0;
    step(); step();
    tests++; if (imem_bus.req !== 1'b0) begin failed++; $display("FAIL reset_req: got %0b exp 0", imem_bus.req); end
    tests++; if (imem_bus.addr !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h exp 0", imem_bus.addr); end
    tests++; if (if_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %0b exp 0", if_valid); end
    tests++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin failed++; $display("FAIL reset_if: pc %h instr %h exp 0 0", if_pc, if_instr); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    reset = 1'b0;
    step();
    $display("[TB] reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'(i * 4);
      tests++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== exp_addr || if_valid !== 1'b0) begin
        failed++; $display("FAIL seq_req%0d: req %0b addr %h valid %0b exp 1 %h 0", i, imem_bus.req, imem_bus.addr, if_valid, exp_addr);
      end
      imem_bus.ack = 1'b1; imem_bus.rdata = 32'hA000_0000 | exp_addr;
      step();
      imem_bus.ack = 1'b0;
      tests++; if (if_valid !== 1'b1 || if_pc !== exp_addr || if_instr !== (32'hA000_0000 | exp_addr)) begin
        failed++; $display("FAIL seq_out%0d: valid %0b pc %h instr %h exp 1 %h %h", i, if_valid, if_pc, if_instr, exp_addr, 32'hA000_0000 | exp_addr);
      end
      tests++; if (imem_bus.req !== 1'b0 || imem_bus.addr !== exp_addr + 32'd4) begin
        failed++; $display("FAIL seq_next%0d: req %0b addr %h exp 0 %h", i, imem_bus.req, imem_bus.addr, exp_addr + 32'd4);
      end
      $display("[TB] seq fetch addr=%h instr=%h", if_pc, if_instr);
      step();
    end
  endtask

  task automatic test_stall();
    tests++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'hC) begin failed++; $display("FAIL stall_pre: req %0b addr %h exp 1 0000000c", imem_bus.req, imem_bus.addr); end
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF; stall = 1'b1;
    step();
    imem_bus.ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'hDEAD_BEEF || imem_bus.req !== 1'b0) begin
        failed++; $display("FAIL stall_hold%0d: valid %0b pc %h instr %h req %0b exp 1 0000000c deadbeef 0", i, if_valid, if_pc, if_instr, imem_bus.req);
      end
      step();
    end
    stall = 1'b0;
    step();
    tests++; if (if_valid !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h10) begin
      failed++; $display("FAIL stall_release: valid %0b req %0b addr %h exp 0 1 00000010", if_valid, imem_bus.req, imem_bus.addr);
    end
    $display("[TB] stall held 5 cycles, next addr=%h", imem_bus.addr);
  endtask

  task automatic test_redirect_pending();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h10 || if_valid !== 1'b0) begin
        failed++; $display("FAIL pend_hold%0d: req %0b addr %h valid %0b exp 1 00000010 0", i, imem_bus.req, imem_bus.addr, if_valid);
      end
      if (i < 2) step();
    end
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0BAD_0BAD;
    step();
    imem_bus.ack = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100) begin
      failed++; $display("FAIL pend_drop: valid %0b req %0b addr %h exp 0 1 00000100", if_valid, imem_bus.req, imem_bus.addr);
    end
    $display("[TB] pending redirect, next addr=%h", imem_bus.addr);
  endtask

  task automatic test_redirect_ack();
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h5555_5555;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    imem_bus.ack = 1'b0; redirect_valid = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h40) begin
      failed++; $display("FAIL redir_ack: valid %0b req %0b addr %h exp 0 1 00000040", if_valid, imem_bus.req, imem_bus.addr);
    end
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h1111_1111;
    step();
    imem_bus.ack = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1111_1111 || imem_bus.addr !== 32'h44) begin
      failed++; $display("FAIL redir_fetch: valid %0b pc %h instr %h addr %h exp 1 00000040 11111111 00000044", if_valid, if_pc, if_instr, imem_bus.addr);
    end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h200) begin
      failed++; $display("FAIL redir_out: valid %0b req %0b addr %h exp 0 1 00000200", if_valid, imem_bus.req, imem_bus.addr);
    end
    $display("[TB] redirect during S_OUT, next addr=%h", imem_bus.addr);
  endtask

  task automatic test_wrap();
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    tests++; if (imem_bus.addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_pre: addr %h exp fffffffc", imem_bus.addr); end
    imem_bus.rdata = 32'h7777_0000;
    step();
    imem_bus.ack = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || imem_bus.addr !== 32'h0) begin
      failed++; $display("FAIL wrap: valid %0b pc %h addr %h exp 1 fffffffc 00000000", if_valid, if_pc, imem_bus.addr);
    end
    step();
    tests++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin failed++; $display("FAIL wrap_req: req %0b addr %h exp 1 00000000", imem_bus.req, imem_bus.addr); end
    $display("[TB] wrap, next addr=%h", imem_bus.addr);
  endtask

  task automatic test_start_drop();
    start = 1'b0;
    step();
    tests++; if (imem_bus.req !== 1'b1 || busy !== 1'b1) begin failed++; $display("FAIL drop_keep: req %0b busy %0b exp 1 1", imem_bus.req, busy); end
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h2222_2222;
    step();
    imem_bus.ack = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_instr !== 32'h2222_2222 || if_pc !== 32'h0) begin
      failed++; $display("FAIL drop_deliver: valid %0b pc %h instr %h exp 1 00000000 22222222", if_valid, if_pc, if_instr);
    end
    step();
    tests++; if (if_valid !== 1'b0 || imem_bus.req !== 1'b0 || busy !== 1'b0 || imem_bus.addr !== 32'h4) begin
      failed++; $display("FAIL drop_idle: valid %0b req %0b busy %0b addr %h exp 0 0 0 00000004", if_valid, imem_bus.req, busy, imem_bus.addr);
    end
    imem_bus.ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h81;
    step();
    imem_bus.ack = 1'b0; redirect_valid = 1'b0;
    tests++; if (imem_bus.addr !== 32'h80 || busy !== 1'b0 || imem_bus.req !== 1'b0 || if_valid !== 1'b0) begin
      failed++; $display("FAIL idle_redir: addr %h busy %0b req %0b valid %0b exp 00000080 0 0 0", imem_bus.addr, busy, imem_bus.req, if_valid);
    end
    $display("[TB] start dropped, idle addr=%h", imem_bus.addr);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    tests++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h80) begin failed++; $display("FAIL rmid_req: req %0b addr %h exp 1 00000080", imem_bus.req, imem_bus.addr); end
    reset = 1'b1;
    #1;
    tests++; if (imem_bus.req !== 1'b0 || imem_bus.addr !== 32'h0 || busy !== 1'b0) begin
      failed++; $display("FAIL rmid_async: req %0b addr %h busy %0b exp 0 00000000 0", imem_bus.req, imem_bus.addr, busy);
    end
    start = 1'b0;
    step();
    reset = 1'b0;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h3333_3333;
    step();
    imem_bus.ack = 1'b0;
    tests++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_bus.req !== 1'b0 || busy !== 1'b0 || imem_bus.addr !== 32'h0) begin
      failed++; $display("FAIL rmid_ignore: valid %0b instr %h req %0b busy %0b addr %h exp 0 00000000 0 0 00000000", if_valid, if_instr, imem_bus.req, busy, imem_bus.addr);
    end
    $display("[TB] reset mid-transaction, late ack ignored");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_pending();
    test_redirect_ack();
    test_wrap();
    test_start_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
